fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_addsub.sv | 23 ++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: halt opcode, reset PC default and fetch FSM encoding.
// Pure declarations; no latency or flow control of its own.
package fetch_unit_pkg;

  localparam logic [3:0]  HALT_OPCODE      = 4'hF;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_HALTED  = 2'd3
  } fetch_state_e;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:12] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_unit_addsub.sv
// 16-bit modulo adder/subtractor with optional unsigned saturation.
// Combinational, no backpressure.
module addsub_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  input  logic        sat,
  output logic [15:0] y
);

  logic [16:0] raw;

  assign raw = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});

  // raw[16] is carry-out on add and borrow on subtract
  always_comb begin
    y = raw[15:0];
    if (sat && raw[16]) begin
      y = sub ? 16'h0000 : 16'hFFFF;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request feeding the IF/ID register.
// Data lands in IF/ID the edge imem_valid is seen; stall parks it in a one-entry hold buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic        if_id_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_inc,
  output logic        halted
);

  fetch_state_e state_q;
  logic [15:0]  pc_q;
  logic [15:0]  req_addr_q;
  logic [15:0]  hold_buf_q;
  logic [15:0]  hold_pc_inc_q;
  logic         if_id_valid_q;
  logic [15:0]  if_id_instr_q;
  logic [15:0]  if_id_pc_inc_q;
  logic         halted_q;

  logic [15:0]  addr_inc;
  logic         deliver;
  logic [15:0]  dlv_instr;
  logic [15:0]  dlv_pc_inc;

  addsub_16bit u_pc_inc (
    .a   (req_addr_q),
    .b   (16'h0002),
    .sub (1'b0),
    .sat (1'b0),
    .y   (addr_inc)
  );

  // req_addr_q still points at the held word in HOLD, so both sources agree on pc+2
  assign deliver    = !redirect && !stall &&
                      (((state_q == ST_REQ) && imem_valid) || (state_q == ST_HOLD));
  assign dlv_instr  = (state_q == ST_HOLD) ? hold_buf_q    : imem_data;
  assign dlv_pc_inc = (state_q == ST_HOLD) ? hold_pc_inc_q : addr_inc;

  assign imem_req     = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign imem_addr    = req_addr_q;
  assign if_id_valid  = if_id_valid_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_pc_inc = if_id_pc_inc_q;
  assign halted       = halted_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_REQ;
      pc_q           <= RESET_PC;
      req_addr_q     <= RESET_PC;
      hold_buf_q     <= 16'h0000;
      hold_pc_inc_q  <= 16'h0000;
      if_id_valid_q  <= 1'b0;
      if_id_instr_q  <= 16'h0000;
      if_id_pc_inc_q <= 16'h0000;
      halted_q       <= 1'b0;
    end else if (redirect) begin
      if_id_valid_q <= 1'b0;
      pc_q          <= redirect_pc;
      case (state_q)
        ST_REQ: begin
          if (imem_valid) req_addr_q <= redirect_pc;
          else            state_q    <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (imem_valid) begin
            req_addr_q <= redirect_pc;
            state_q    <= ST_REQ;
          end
        end
        default: begin
          req_addr_q <= redirect_pc;
          halted_q   <= 1'b0;
          state_q    <= ST_REQ;
        end
      endcase
    end else if (deliver) begin
      if_id_valid_q  <= 1'b1;
      if_id_instr_q  <= dlv_instr;
      if_id_pc_inc_q <= dlv_pc_inc;
      if (is_halt(dlv_instr)) begin
        pc_q     <= req_addr_q;
        halted_q <= 1'b1;
        state_q  <= ST_HALTED;
      end else begin
        pc_q       <= dlv_pc_inc;
        req_addr_q <= dlv_pc_inc;
        state_q    <= ST_REQ;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem_valid) begin
            hold_buf_q    <= imem_data;
            hold_pc_inc_q <= addr_inc;
            state_q       <= ST_HOLD;
          end else if (!stall) begin
            if_id_valid_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!stall) if_id_valid_q <= 1'b0;
          // the stale response is dropped; refetch from the redirected pc
          if (imem_valid) begin
            req_addr_q <= pc_q;
            state_q    <= ST_REQ;
          end
        end
        ST_HOLD: begin
          state_q <= ST_HOLD;
        end
        ST_HALTED: begin
          if (!stall) if_id_valid_q <= 1'b0;
        end
        default: state_q <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, then randomized traffic vs a flag-based model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_valid = 1'b0;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_inc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .imem_valid   (imem_valid),
    .if_id_valid  (if_id_valid),
    .if_id_instr  (if_id_instr),
    .if_id_pc_inc (if_id_pc_inc),
    .halted       (halted)
  );

  typedef struct {
    bit          rst;
    bit          stl;
    bit          rd;
    logic [15:0] rpc;
    bit          vld;
    logic [15:0] dat;
    logic [50:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [50:0] pack_out(input bit req, input logic [15:0] addr, input bit v,
                                           input logic [15:0] instr, input logic [15:0] inc,
                                           input bit h);
    return {req, addr, v, instr, inc, h};
  endfunction

  task automatic add(input bit rst, input bit stl, input bit rd, input logic [15:0] rpc,
                     input bit vld, input logic [15:0] dat, input bit e_req,
                     input logic [15:0] e_addr, input bit e_v, input logic [15:0] e_instr,
                     input logic [15:0] e_inc, input bit e_h);
    vec_t t;
    t.rst = rst; t.stl = stl; t.rd = rd; t.rpc = rpc; t.vld = vld; t.dat = dat;
    t.exp = pack_out(e_req, e_addr, e_v, e_instr, e_inc, e_h);
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [50:0] act, input logic [50:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got req=%0b addr=%h v=%0b instr=%h inc=%h halt=%0b want req=%0b addr=%h v=%0b instr=%h inc=%h halt=%0b",
               name, act[50], act[49:34], act[33], act[32:17], act[16:1], act[0],
               exp[50], exp[49:34], exp[33], exp[32:17], exp[16:1], exp[0]);
    end
  endtask

  function automatic logic [50:0] dut_out();
    return {imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc_inc, halted};
  endfunction

  // Reference model: a fetch pointer plus "parked word" / "halted" / "draining" flags.
  logic [15:0] m_pc, m_addr, m_hbuf, m_hinc, m_instr, m_inc;
  bit          m_held, m_halt, m_drain, m_v;

  function automatic logic [50:0] model_out();
    return pack_out(!m_held && !m_halt, m_addr, m_v, m_instr, m_inc, m_halt);
  endfunction

  task automatic model_step(input bit r, input bit st, input bit rd, input logic [15:0] rpc,
                            input bit v, input logic [15:0] d);
    bit          dlv;
    logic [15:0] di, dinc;
    dlv = 0; di = 16'h0; dinc = 16'h0;
    if (r) begin
      m_pc = 16'h0; m_addr = 16'h0; m_hbuf = 16'h0; m_hinc = 16'h0;
      m_instr = 16'h0; m_inc = 16'h0; m_held = 0; m_halt = 0; m_drain = 0; m_v = 0;
    end else if (rd) begin
      m_v = 0; m_pc = rpc;
      if (m_halt || m_held) begin
        m_halt = 0; m_held = 0; m_addr = rpc;
      end else if (m_drain) begin
        if (v) begin m_drain = 0; m_addr = rpc; end
      end else if (v) begin
        m_addr = rpc;
      end else begin
        m_drain = 1;
      end
    end else if (m_drain) begin
      if (!st) m_v = 0;
      if (v) begin m_drain = 0; m_addr = m_pc; end
    end else if (m_halt) begin
      if (!st) m_v = 0;
    end else if (m_held) begin
      if (!st) begin dlv = 1; di = m_hbuf; dinc = m_hinc; end
    end else if (v) begin
      if (st) begin m_held = 1; m_hbuf = d; m_hinc = m_addr + 16'd2; end
      else begin dlv = 1; di = d; dinc = m_addr + 16'd2; end
    end else if (!st) begin
      m_v = 0;
    end
    if (dlv) begin
      m_v = 1; m_instr = di; m_inc = dinc; m_held = 0;
      if (di[15:12] == 4'hF) m_halt = 1;
      else begin m_pc = dinc; m_addr = dinc; end
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit rd, input logic [15:0] rpc,
                       input bit v, input logic [15:0] d);
    rst_n = !r; stall = st; redirect = rd; redirect_pc = rpc; imem_valid = v; imem_data = d;
  endtask

  initial begin
    bit          busy;
    int          lat, cnt;
    bit          r, st, rd, v;
    logic [15:0] rpc, d;

    //   rst stl rd  rpc       vld dat       req addr      v  instr     inc       halt
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0); // reset
    add(0, 0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0002, 1, 16'h1111, 16'h0002, 0); // zero latency
    add(0, 0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0004, 1, 16'h2222, 16'h0004, 0);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 16'h2222, 16'h0004, 0); // 3-cycle latency
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 16'h2222, 16'h0004, 0);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 16'h2222, 16'h0004, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0006, 1, 16'h3333, 16'h0006, 0);
    add(0, 1, 0, 16'h0000, 1, 16'h4444, 0, 16'h0006, 1, 16'h3333, 16'h0006, 0); // stall -> hold
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0006, 1, 16'h3333, 16'h0006, 0);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 1, 16'h4444, 16'h0008, 0); // release
    add(0, 0, 1, 16'h0010, 1, 16'h5555, 1, 16'h0010, 0, 16'h4444, 16'h0008, 0); // redirect on data
    add(0, 0, 1, 16'h0100, 0, 16'h0000, 1, 16'h0010, 0, 16'h4444, 16'h0008, 0); // redirect pending
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 0, 16'h4444, 16'h0008, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h6666, 1, 16'h0100, 0, 16'h4444, 16'h0008, 0); // dropped
    add(0, 0, 0, 16'h0000, 1, 16'h7777, 1, 16'h0102, 1, 16'h7777, 16'h0102, 0);
    add(0, 0, 1, 16'h0020, 0, 16'h0000, 1, 16'h0102, 0, 16'h7777, 16'h0102, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h8888, 1, 16'h0020, 0, 16'h7777, 16'h0102, 0);
    add(0, 0, 0, 16'h0000, 1, 16'hF000, 0, 16'h0020, 1, 16'hF000, 16'h0022, 1); // HLT
    add(0, 0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0020, 0, 16'hF000, 16'h0022, 1); // valid ignored
    add(0, 0, 1, 16'h0040, 0, 16'h0000, 1, 16'h0040, 0, 16'hF000, 16'h0022, 0); // restart
    add(0, 0, 0, 16'h0000, 1, 16'h0ABC, 1, 16'h0042, 1, 16'h0ABC, 16'h0042, 0);
    add(0, 0, 1, 16'hFFFE, 1, 16'h9999, 1, 16'hFFFE, 0, 16'h0ABC, 16'h0042, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h1357, 1, 16'h0000, 1, 16'h1357, 16'h0000, 0); // wrap
    add(0, 0, 1, 16'h0200, 0, 16'h0000, 1, 16'h0000, 0, 16'h1357, 16'h0000, 0); // into DRAIN
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0); // reset mid-drain
    add(0, 0, 0, 16'h0000, 1, 16'h2468, 1, 16'h0002, 1, 16'h2468, 16'h0002, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].stl, vecs[i].rd, vecs[i].rpc, vecs[i].vld, vecs[i].dat);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    busy = 0; lat = 0; cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      r   = (n == 0) || ($urandom % 100 == 0);
      st  = ($urandom % 3 == 0);
      rd  = ($urandom % 8 == 0);
      rpc = ($urandom % 8 == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);
      if (imem_req) begin
        if (!busy) begin busy = 1; cnt = 0; lat = $urandom_range(0, 3); end
        v = (cnt == lat);
      end else begin
        v = ($urandom % 2 == 1);
      end
      d = 16'($urandom);
      if (d[15:12] == 4'hF && $urandom % 2 == 0) d[15:12] = 4'h1;
      drive(r, st, rd, rpc, v, d);
      model_step(r, st, rd, rpc, v, d);
      @(posedge clk);
      #1;
      if (r) busy = 0;
      else if (busy) begin
        if (v) busy = 0;
        else cnt++;
      end
      check("rand", dut_out(), model_out());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
